popcount_pipe: RTL and testbench

//  Parametrised, pipelined population count over a WIDTH-bit word, streamed with valid/ready.

---
 rtl/popcount_pipe_pkg.sv | 38 +++
 rtl/adder_1bit_half.sv | 25 ++
 rtl/adder_nbit_cout.sv | 39 +++
 rtl/popcount_tree_level.sv | 46 ++++
 rtl/popcount_pipe.sv | 179 +++++++++++++++++
 tb/tb_popcount_pipe.sv | 303 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/popcount_pipe_pkg.sv
// ---------------------------------------------------------------------------
// popcount_pipe_pkg
// Purpose : shared helpers for the pipelined population counter.
//   clog2()      - ceiling log2 for elaboration-time sizing
//   calc_cw()    - width of a popcount result for a given word width
//   calc_depth() - number of pipeline stages for a given register spacing
//   beat_ctrl_t  - sideband that travels with each beat through the pipe
// Ports   : none (package)
// ---------------------------------------------------------------------------
package popcount_pipe_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // A WIDTH-bit word can hold up to WIDTH ones; WIDTH = 2^L needs L+1 bits.
    function automatic int calc_cw(input int width);
        return clog2(width) + 1;
    endfunction

    // One register after every reg_every tree levels, plus one after the
    // final level when L is not a multiple of reg_every: ceil(L / reg_every).
    function automatic int calc_depth(input int width, input int reg_every);
        return (clog2(width) + reg_every - 1) / reg_every;
    endfunction

    typedef struct packed {
        logic valid;
        logic acc_en;
        logic last;
    } beat_ctrl_t;

endpackage

// File: rtl/adder_1bit_half.sv
// ---------------------------------------------------------------------------
// adder_1bit_half
// Purpose : 1-bit half adder, first level of the popcount tree.
// Params  : IMPL_TYPE - 0 = arithmetic operator, otherwise explicit XOR/AND
// Ports   : a, b   in  1  operand bits
//           sum    out 1  a ^ b
//           carry  out 1  a & b
// ---------------------------------------------------------------------------
module adder_1bit_half #(
    parameter int IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    if (IMPL_TYPE == 0) begin : gen_behav
        assign {carry, sum} = {1'b0, a} + {1'b0, b};
    end else begin : gen_gate
        assign sum   = a ^ b;
        assign carry = a & b;
    end

endmodule

// File: rtl/adder_nbit_cout.sv
// ---------------------------------------------------------------------------
// adder_nbit_cout
// Purpose : N-bit unsigned adder with carry-out, used by tree levels >= 1.
// Params  : N         - operand width
//           IMPL_TYPE - 0 = arithmetic operator, otherwise explicit ripple carry
// Ports   : a, b   in  N  operands
//           sum    out N  low N bits of a + b
//           cout   out 1  carry out of bit N-1
// ---------------------------------------------------------------------------
module adder_nbit_cout #(
    parameter int N         = 2,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    if (IMPL_TYPE == 0) begin : gen_behav
        assign {cout, sum} = {1'b0, a} + {1'b0, b};
    end else begin : gen_ripple
        // The carry is kept in a block-local variable so the chain is a
        // sequence of blocking updates, not a self-referencing vector.
        always_comb begin : ripple
            logic carry;
            // NOTE: every output of a combinational block gets a value on
            // every path before anything else, otherwise a latch is inferred.
            sum   = '0;
            carry = 1'b0;
            for (int i = 0; i < N; i++) begin
                sum[i] = a[i] ^ b[i] ^ carry;
                carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
            end
            cout = carry;
        end
    end

endmodule

// File: rtl/popcount_tree_level.sv
// ---------------------------------------------------------------------------
// popcount_tree_level
// Purpose : one combinational level of the popcount adder tree. Adds
//           adjacent pairs of IN_W-bit partial counts into (IN_W+1)-bit
//           counts; the carry-out becomes the new MSB so nothing overflows.
// Params  : IN_W      - width of each incoming partial count
//           N_IN      - number of incoming partial counts (even)
//           IMPL_TYPE - forwarded to every adder instance
// Ports   : din   in  N_IN*IN_W            packed partial counts, entry 0 at LSB
//           dout  out (N_IN/2)*(IN_W+1)    packed pairwise sums, entry 0 at LSB
// ---------------------------------------------------------------------------
module popcount_tree_level #(
    parameter  int IN_W      = 1,
    parameter  int N_IN      = 2,
    parameter  int IMPL_TYPE = 0,
    localparam int N_OUT     = N_IN / 2,
    localparam int OUT_W     = IN_W + 1
) (
    input  logic [N_IN*IN_W-1:0]   din,
    output logic [N_OUT*OUT_W-1:0] dout
);

    for (genvar i = 0; i < N_OUT; i++) begin : gen_pair
        if (IN_W == 1) begin : gen_half
            adder_1bit_half #(
                .IMPL_TYPE (IMPL_TYPE)
            ) u_add (
                .a     (din[2*i]),
                .b     (din[2*i+1]),
                .sum   (dout[i*OUT_W]),
                .carry (dout[i*OUT_W+1])
            );
        end else begin : gen_full
            adder_nbit_cout #(
                .N         (IN_W),
                .IMPL_TYPE (IMPL_TYPE)
            ) u_add (
                .a    (din[(2*i)*IN_W +: IN_W]),
                .b    (din[(2*i+1)*IN_W +: IN_W]),
                .sum  (dout[i*OUT_W +: IN_W]),
                .cout (dout[i*OUT_W+IN_W])
            );
        end
    end

endmodule

// File: rtl/popcount_pipe.sv
// ---------------------------------------------------------------------------
// popcount_pipe
// Purpose : pipelined population count of a WIDTH-bit word with valid/ready
//           streaming, plus an optional saturating per-packet running total.
// Params  : WIDTH     - word width, power of two (2..256); L = log2(WIDTH)
//           REG_EVERY - stage register after every REG_EVERY tree levels (1..L)
//           ACC_WIDTH - running-total width, >= CW
//           IMPL_TYPE - forwarded to every adder in the tree
// Ports   : clk        in  1          rising-edge clock
//           rst        in  1          asynchronous active-high reset
//           in_valid   in  1          input beat valid
//           in_ready   out 1          pipe can take a beat this cycle
//           A          in  WIDTH      word to count
//           acc_en     in  1          beat contributes to the running total
//           in_last    in  1          beat closes the packet (when acc_en=1)
//           out_valid  out 1          Y holds a beat
//           out_ready  in  1          downstream takes Y this cycle
//           Y          out CW         popcount of the beat
//           acc_valid  out 1          one-cycle pulse: acc_Y is a new total
//           acc_Y      out ACC_WIDTH  last completed packet total
//           acc_sat    out 1          that total was clipped
// ---------------------------------------------------------------------------
module popcount_pipe
    import popcount_pipe_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int REG_EVERY = 1,
    parameter  int ACC_WIDTH = 16,
    parameter  int IMPL_TYPE = 0,
    localparam int CW        = calc_cw(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic                 acc_en,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        Y,
    output logic                 acc_valid,
    output logic [ACC_WIDTH-1:0] acc_Y,
    output logic                 acc_sat
);

    localparam int L = clog2(WIDTH);
    localparam int P = calc_depth(WIDTH, REG_EVERY);

    // Stall-all: the whole pipe moves together whenever the output slot is
    // empty or being drained, so bubbles are simply overwritten.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // -----------------------------------------------------------------------
    // Adder tree. Level k turns (WIDTH>>k) counts of k+1 bits into half as
    // many counts of k+2 bits. Each level's node_out is either its raw sum or
    // the stage register that follows it.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < L; k++) begin : gen_level
        localparam int IN_W    = k + 1;
        localparam int N_IN    = WIDTH >> k;
        localparam int BUS_IN  = N_IN * IN_W;
        localparam int BUS_OUT = (N_IN / 2) * (IN_W + 1);

        logic [BUS_IN-1:0]  lvl_in;
        logic [BUS_OUT-1:0] lvl_sum;
        logic [BUS_OUT-1:0] node_out;

        if (k == 0) begin : gen_src_word
            assign lvl_in = A;
        end else begin : gen_src_prev
            assign lvl_in = gen_level[k-1].node_out;
        end

        popcount_tree_level #(
            .IN_W      (IN_W),
            .N_IN      (N_IN),
            .IMPL_TYPE (IMPL_TYPE)
        ) u_level (
            .din  (lvl_in),
            .dout (lvl_sum)
        );

        // The last level is always registered so Y comes straight from a flop.
        if (((k + 1) % REG_EVERY == 0) || (k == L - 1)) begin : gen_reg
            logic [BUS_OUT-1:0] lvl_q;

            // NOTE: data stages are reset along with the valids so Y reads 0
            // out of reset; they are a handful of pipeline flops, not a RAM.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lvl_q <= '0;
                end else if (adv) begin
                    lvl_q <= lvl_sum;
                end
            end

            assign node_out = lvl_q;
        end else begin : gen_wire
            assign node_out = lvl_sum;
        end
    end

    assign Y = gen_level[L-1].node_out;

    // -----------------------------------------------------------------------
    // Sideband pipe, one entry per stage register, moving in lockstep with
    // the data. acc_en/last are qualified by valid so bubbles carry nothing.
    // -----------------------------------------------------------------------
    beat_ctrl_t ctrl_q [P];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // stage samples its neighbour's pre-edge value; blocking here would let a
    // beat skip stages within one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < P; s++) begin
                ctrl_q[s] <= '0;
            end
        end else if (adv) begin
            ctrl_q[0].valid  <= in_valid;
            ctrl_q[0].acc_en <= in_valid && acc_en;
            ctrl_q[0].last   <= in_valid && acc_en && in_last;
            for (int s = 1; s < P; s++) begin
                ctrl_q[s] <= ctrl_q[s-1];
            end
        end
    end

    assign out_valid = ctrl_q[P-1].valid;

    // -----------------------------------------------------------------------
    // Running total. Updated only when an acc_en beat leaves the pipe; one
    // extra bit on the adder detects the clip.
    // -----------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 sticky_q;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 clip;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 acc_fire;

    always_comb begin
        sum_wide = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - CW){1'b0}}, Y};
        clip     = sum_wide[ACC_WIDTH];
        sum_sat  = clip ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
    end

    assign acc_fire = out_valid && out_ready && ctrl_q[P-1].acc_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            acc_Y     <= '0;
            acc_sat   <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (acc_fire) begin
                if (ctrl_q[P-1].last) begin
                    // Publish the packet and start the next one from zero.
                    acc_Y     <= sum_sat;
                    acc_sat   <= sticky_q || clip;
                    acc_valid <= 1'b1;
                    acc_q     <= '0;
                    sticky_q  <= 1'b0;
                end else begin
                    acc_q    <= sum_sat;
                    sticky_q <= sticky_q || clip;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_pipe.sv
// ---------------------------------------------------------------------------
// tb_popcount_pipe
// Three instances: dut_a (WIDTH=8, REG_EVERY=1, ACC_WIDTH=16, operator adders),
// dut_s (same word path with ACC_WIDTH=4 and ripple adders, sharing dut_a's
// stimulus) and dut_w (WIDTH=64, REG_EVERY=2). Inputs change 1 time unit
// after the rising edge; monitors record handshakes on the falling edge.
// ---------------------------------------------------------------------------
module tb_popcount_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for the 8-bit instances
    logic       in_valid, acc_en, in_last, out_ready;
    logic [7:0] a8;

    logic        a_in_ready, a_out_valid, a_acc_valid, a_acc_sat;
    logic [3:0]  a_y;
    logic [15:0] a_acc_y;

    logic        s_in_ready, s_out_valid, s_acc_valid, s_acc_sat;
    logic [3:0]  s_y;
    logic [3:0]  s_acc_y;

    logic        w_in_valid, w_out_ready;
    logic [63:0] w_a;
    logic        w_in_ready, w_out_valid, w_acc_valid, w_acc_sat;
    logic [6:0]  w_y;
    logic [15:0] w_acc_y;

    popcount_pipe #(.WIDTH(8), .REG_EVERY(1), .ACC_WIDTH(16), .IMPL_TYPE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .A(a8),
        .acc_en(acc_en), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
        .Y(a_y), .acc_valid(a_acc_valid), .acc_Y(a_acc_y), .acc_sat(a_acc_sat)
    );

    popcount_pipe #(.WIDTH(8), .REG_EVERY(1), .ACC_WIDTH(4), .IMPL_TYPE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .A(a8),
        .acc_en(acc_en), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .Y(s_y), .acc_valid(s_acc_valid), .acc_Y(s_acc_y), .acc_sat(s_acc_sat)
    );

    popcount_pipe #(.WIDTH(64), .REG_EVERY(2), .ACC_WIDTH(16), .IMPL_TYPE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .A(w_a),
        .acc_en(1'b0), .in_last(1'b0), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .Y(w_y), .acc_valid(w_acc_valid), .acc_Y(w_acc_y), .acc_sat(w_acc_sat)
    );

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  a_q[$];
    int          a_cyc[$];
    logic [3:0]  s_q[$];
    logic [6:0]  w_q[$];
    int          w_cyc[$];
    logic [15:0] a_accq[$];
    logic        a_satq[$];
    logic [3:0]  s_accq[$];
    logic        s_satq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && out_ready) begin
                a_q.push_back(a_y);
                a_cyc.push_back(cyc);
            end
            if (s_out_valid && out_ready) s_q.push_back(s_y);
            if (w_out_valid && w_out_ready) begin
                w_q.push_back(w_y);
                w_cyc.push_back(cyc);
            end
            if (a_acc_valid) begin
                a_accq.push_back(a_acc_y);
                a_satq.push_back(a_acc_sat);
            end
            if (s_acc_valid) begin
                s_accq.push_back(s_acc_y);
                s_satq.push_back(s_acc_sat);
            end
        end
    end

    // ---------------- helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_queues();
        a_q.delete(); a_cyc.delete(); s_q.delete(); w_q.delete(); w_cyc.delete();
        a_accq.delete(); a_satq.delete(); s_accq.delete(); s_satq.delete();
    endtask

    // One beat into the 8-bit instances, waiting (bounded) for in_ready.
    task automatic send8(input logic [7:0] val, input logic en, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a8       = val;
        acc_en   = en;
        in_last  = last;
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send8_ready_timeout", 64'(n), 0);
        tick();
        in_valid = 1'b0;
        acc_en   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send64(input logic [63:0] val);
        w_in_valid = 1'b1;
        w_a        = val;
        tick();
        w_in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp2 [4];
        logic [3:0] exp3 [4];
        logic [6:0] expw [5];
        int         n;

        rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; in_last = 1'b0; out_ready = 1'b1; a8 = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0;
        drain(3);

        // Reset state
        check("rst_out_valid",   a_out_valid, 0);
        check("rst_y",           a_y, 0);
        check("rst_acc_valid",   a_acc_valid, 0);
        check("rst_acc_y",       a_acc_y, 0);
        check("rst_acc_sat",     a_acc_sat, 0);
        check("rst_in_ready",    a_in_ready, 1);
        check("rst_s_out_valid", s_out_valid, 0);
        check("rst_s_in_ready",  s_in_ready, 1);
        check("rst_w_out_valid", w_out_valid, 0);
        check("rst_w_in_ready",  w_in_ready, 1);
        check("rst_w_acc",       {w_acc_valid, w_acc_sat, w_acc_y}, 0);
        rst = 1'b0;
        drain(1);

        // Test 1: latency 3, FF -> 8
        in_valid = 1'b1; a8 = 8'hFF;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", 64'(n), 3);
        check("t1_y", a_y, 8);
        drain(2);
        check("t1_drained", a_out_valid, 0);

        // Test 2: back-to-back, results on consecutive cycles
        clear_queues();
        exp2 = '{4'd0, 4'd1, 4'd4, 4'd8};
        send8(8'h00, 0, 0); send8(8'h01, 0, 0); send8(8'hA5, 0, 0); send8(8'hFF, 0, 0);
        drain(6);
        check("t2_count", 64'(a_q.size()), 4);
        check("t2_s_count", 64'(s_q.size()), 4);
        if (a_q.size() == 4 && s_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t2_y%0d", i), a_q[i], exp2[i]);
                check($sformatf("t2_s_y%0d", i), s_q[i], exp2[i]);
            end
            for (int i = 1; i < 4; i++) check($sformatf("t2_gap%0d", i), 64'(a_cyc[i] - a_cyc[i-1]), 1);
        end

        // Test 3: backpressure with full pipe and a pending beat
        clear_queues();
        exp3 = '{4'd2, 4'd3, 4'd5, 4'd6};
        out_ready = 1'b0;
        send8(8'h03, 0, 0); send8(8'h07, 0, 0); send8(8'h1F, 0, 0);
        in_valid = 1'b1; a8 = 8'h3F;
        for (int i = 0; i < 5; i++) begin
            check("t3_in_ready",  a_in_ready, 0);
            check("t3_out_valid", a_out_valid, 1);
            check("t3_y_stable",  a_y, 2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(6);
        check("t3_count", 64'(a_q.size()), 4);
        if (a_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("t3_y%0d", i), a_q[i], exp3[i]);
        end

        // Test 4: packet 0F, (FF without acc_en), F0, 03 last -> 10; next packet 01 -> 1
        clear_queues();
        send8(8'h0F, 1, 0); send8(8'hFF, 0, 0); send8(8'hF0, 1, 0); send8(8'h03, 1, 1);
        drain(6);
        check("t4_pulses", 64'(a_accq.size()), 1);
        if (a_accq.size() == 1) begin
            check("t4_acc_y",   a_accq[0], 10);
            check("t4_acc_sat", a_satq[0], 0);
        end
        check("t4_acc_y_held", a_acc_y, 10);
        send8(8'h01, 1, 1);
        drain(6);
        check("t4_next_pulses", 64'(a_accq.size()), 2);
        if (a_accq.size() == 2) check("t4_next_acc_y", a_accq[1], 1);

        // Test 5: saturation on the 4-bit accumulator, then sticky cleared
        clear_queues();
        send8(8'hFF, 1, 0); send8(8'hFF, 1, 0); send8(8'hFF, 1, 1);
        drain(6);
        check("t5_s_pulses", 64'(s_accq.size()), 1);
        if (s_accq.size() == 1) begin
            check("t5_s_acc_y",   s_accq[0], 15);
            check("t5_s_acc_sat", s_satq[0], 1);
        end
        check("t5_a_pulses", 64'(a_accq.size()), 1);
        if (a_accq.size() == 1) begin
            check("t5_a_acc_y",   a_accq[0], 24);
            check("t5_a_acc_sat", a_satq[0], 0);
        end
        send8(8'h01, 1, 1);
        drain(6);
        check("t5_s_next_pulses", 64'(s_accq.size()), 2);
        if (s_accq.size() == 2) begin
            check("t5_s_next_acc_y",   s_accq[1], 1);
            check("t5_s_next_acc_sat", s_satq[1], 0);
        end

        // Test 6: reset with beats in flight and a partial total pending
        send8(8'hFF, 1, 0);
        drain(5);
        send8(8'h01, 1, 0); send8(8'h03, 1, 0); send8(8'h07, 1, 0);
        rst = 1'b1;
        #1;
        check("t6_out_valid_now", a_out_valid, 0);
        check("t6_y_now",         a_y, 0);
        tick();
        rst = 1'b0;
        clear_queues();
        send8(8'h81, 1, 1);
        drain(6);
        check("t6_count", 64'(a_q.size()), 1);
        if (a_q.size() == 1) check("t6_y", a_q[0], 2);
        check("t6_pulses", 64'(a_accq.size()), 1);
        if (a_accq.size() == 1) check("t6_acc_y", a_accq[0], 2);

        // Test 7: WIDTH=64, REG_EVERY=2 -> P=3
        clear_queues();
        w_in_valid = 1'b1; w_a = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("t7_latency", 64'(n), 3);
        check("t7_y", w_y, 64);
        drain(3);
        clear_queues();
        expw = '{7'd0, 7'd1, 7'd2, 7'd32, 7'd64};
        send64(64'h0); send64(64'h1); send64(64'h8000_0000_0000_0001);
        send64(64'h0F0F_0F0F_0F0F_0F0F); send64(64'hFFFF_FFFF_FFFF_FFFF);
        drain(6);
        check("t7_count", 64'(w_q.size()), 5);
        if (w_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("t7_y%0d", i), w_q[i], expw[i]);
            for (int i = 1; i < 5; i++) check($sformatf("t7_gap%0d", i), 64'(w_cyc[i] - w_cyc[i-1]), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
